// File: rtl/sseg_scan_ctrl_pkg.sv
// sseg_pkg: scan state type, blank pattern and default parameters for the 7-segment scan controller
package sseg_pkg;
   typedef enum logic {GUARD, ON} scan_state_t;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam int DEF_N_DIGITS = 8;
   localparam int DEF_PRESCALE = 1024;
   localparam int DEF_SLOT_TICKS = 16;
   localparam int DEF_GUARD_TICKS = 1;
endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// sseg_scan_ctrl_if: host register side and display pins of the scan controller
interface sseg_scan_ctrl_if #(parameter int N_DIGITS = 8);
   logic                wr_en;
   logic [2:0]          wr_addr;
   logic [7:0]          wr_data;
   logic                commit;
   logic [N_DIGITS-1:0] digit_en;
   logic [3:0]          duty;
   logic                commit_pend;
   logic                frame_tick;
   logic [7:0]          sseg;
   logic [N_DIGITS-1:0] an;
   modport master (output wr_en, wr_addr, wr_data, commit, digit_en, duty,
                   input commit_pend, frame_tick, sseg, an);
   modport slave (input wr_en, wr_addr, wr_data, commit, digit_en, duty,
                  output commit_pend, frame_tick, sseg, an);
endinterface

// File: rtl/sseg_scan_ctrl_tick_gen.sv
// tick_gen: free-running PRESCALE-cycle counter producing a 1-cycle scan tick
module tick_gen #(parameter int PRESCALE = 1024) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);
   localparam int CW = $clog2(PRESCALE);
   logic [CW-1:0] r_cnt;
   assign o_tick = r_cnt == CW'(PRESCALE - 1);
   always_ff @(posedge clk)
      if (reset) r_cnt <= '0;
      else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: guarded digit scan with double-buffered patterns committed at frame boundaries.
// Define SSEG_PWM_EN to gate the lit part of each slot by the duty input.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int N_DIGITS    = DEF_N_DIGITS,
   parameter int PRESCALE    = DEF_PRESCALE,
   parameter int SLOT_TICKS  = DEF_SLOT_TICKS,
   parameter int GUARD_TICKS = DEF_GUARD_TICKS
) (
   input logic             clk,
   input logic             reset,
   sseg_scan_ctrl_if.slave bus
);
   localparam int TW = $clog2(SLOT_TICKS);
   localparam logic [TW-1:0] G_LAST = TW'(GUARD_TICKS - 1);
   localparam logic [TW-1:0] ON_LAST = TW'(SLOT_TICKS - GUARD_TICKS - 1);
   localparam logic [2:0] S_LAST = 3'(N_DIGITS - 1);
   scan_state_t r_state, w_state_nx;
   logic [2:0] r_slot, w_slot_nx;
   logic [TW-1:0] r_tcnt, w_tcnt_nx;
   logic [7:0] r_shadow [8];
   logic [7:0] r_active [8];
   logic r_pend, r_frame_tick;
   logic [7:0] r_sseg, w_sseg_nx;
   logic [N_DIGITS-1:0] r_an, w_an_nx, w_sel;
   logic w_tick, w_phase_end, w_boundary, w_lit;
   tick_gen #(.PRESCALE(PRESCALE)) u_tick (.clk(clk), .reset(reset), .o_tick(w_tick));
   always_ff @(posedge clk)
      if (reset) begin
         r_state <= GUARD;
         r_slot <= '0;
         r_tcnt <= '0;
      end else begin
         r_state <= w_state_nx;
         r_slot <= w_slot_nx;
         r_tcnt <= w_tcnt_nx;
      end
   always_comb begin
      w_phase_end = w_tick && r_tcnt == (r_state == ON ? ON_LAST : G_LAST);
      w_boundary = w_phase_end && r_state == ON && r_slot == S_LAST;
      w_state_nx = w_phase_end ? (r_state == ON ? GUARD : ON) : r_state;
      w_slot_nx = (w_phase_end && r_state == ON) ? (r_slot == S_LAST ? 3'd0 : r_slot + 3'd1) : r_slot;
      w_tcnt_nx = w_phase_end ? '0 : r_tcnt + TW'(w_tick);
`ifdef SSEG_PWM_EN
      w_lit = r_state == ON && 32'(r_tcnt) < 32'(bus.duty);
`else
      w_lit = r_state == ON;
`endif
      w_sel = N_DIGITS'(1) << r_slot;
      w_an_nx = (w_lit && |(bus.digit_en & w_sel)) ? ~w_sel : '1;
      w_sseg_nx = w_lit ? r_active[r_slot] : SEG_BLANK;
   end
`ifndef SSEG_PWM_EN
   logic [3:0] w_unused_duty;
   assign w_unused_duty = bus.duty;
`endif
   // the copy uses pre-edge shadow and pend, so boundary-cycle writes/commits land next frame
   always_ff @(posedge clk)
      if (reset) begin
         r_pend <= 1'b0;
         r_frame_tick <= 1'b0;
         r_an <= '1;
         r_sseg <= SEG_BLANK;
         for (int i = 0; i < 8; i++) begin
            r_shadow[i] <= SEG_BLANK;
            r_active[i] <= SEG_BLANK;
         end
      end else begin
         r_frame_tick <= w_boundary;
         r_an <= w_an_nx;
         r_sseg <= w_sseg_nx;
         r_pend <= bus.commit || (r_pend && !w_boundary);
         if (w_boundary && r_pend) r_active <= r_shadow;
         if (bus.wr_en && 32'(bus.wr_addr) < N_DIGITS) r_shadow[bus.wr_addr] <= bus.wr_data;
      end
   assign bus.commit_pend = r_pend;
   assign bus.frame_tick = r_frame_tick;
   assign bus.sseg = r_sseg;
   assign bus.an = r_an;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: directed checks of scan timing, commit semantics, digit enable and duty
module tb_sseg_scan_ctrl;
   localparam int N = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;
   int c = 0;
   sseg_scan_ctrl_if #(.N_DIGITS(N)) bus ();
   sseg_scan_ctrl #(.N_DIGITS(N), .PRESCALE(4), .SLOT_TICKS(4), .GUARD_TICKS(1)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic run_to(input int t);
      while (c < t) step();
   endtask

   task automatic do_reset;
      reset = 1'b1;
      bus.wr_en = 1'b0;
      bus.commit = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      c = 0;
   endtask

   task automatic test_reset;
      do_reset();
      n_cmp++; if (bus.an !== 4'hF) begin n_bad++; $display("FAIL reset_an: got %b want 1111", bus.an); end
      n_cmp++; if (bus.sseg !== 8'hFF) begin n_bad++; $display("FAIL reset_sseg: got %h want ff", bus.sseg); end
      n_cmp++; if (bus.commit_pend !== 1'b0) begin n_bad++; $display("FAIL reset_pend: got %b want 0", bus.commit_pend); end
      n_cmp++; if (bus.frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_ftick: got %b want 0", bus.frame_tick); end
   endtask

   task automatic test_scan;
      int cc [10] = '{4, 5, 16, 17, 21, 37, 53, 64, 65, 69};
      logic [3:0] ea [10] = '{4'hF, 4'hE, 4'hE, 4'hF, 4'hD, 4'hB, 4'h7, 4'h7, 4'hF, 4'hE};
      int lows [N];
      int ft, bad_ft, bad_s;
      ft = 0; bad_ft = 0; bad_s = 0;
      for (int i = 0; i < N; i++) lows[i] = 0;
      do_reset();
      repeat (128) begin
         step();
         for (int k = 0; k < 10; k++)
            if (c == cc[k]) begin
               n_cmp++;
               if (bus.an !== ea[k]) begin n_bad++; $display("FAIL scan_an@%0d: got %b want %b", c, bus.an, ea[k]); end
            end
         if (c <= 64) for (int i = 0; i < N; i++) if (bus.an[i] === 1'b0) lows[i]++;
         if (bus.frame_tick === 1'b1) begin ft++; if (c != 64 && c != 128) bad_ft++; end
         if (bus.sseg !== 8'hFF) bad_s++;
      end
      for (int i = 0; i < N; i++) begin
         n_cmp++; if (lows[i] != 12) begin n_bad++; $display("FAIL scan_low_d%0d: got %0d want 12", i, lows[i]); end
      end
      n_cmp++; if (ft != 2 || bad_ft != 0) begin n_bad++; $display("FAIL scan_ftick: got %0d pulses (%0d misplaced) want 2 at 64/128", ft, bad_ft); end
      n_cmp++; if (bad_s != 0) begin n_bad++; $display("FAIL scan_sseg: got %0d non-ff cycles want 0", bad_s); end
   endtask

   task automatic test_commit;
      int seen;
      seen = 0;
      do_reset();
      bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'hA4;
      step();
      bus.wr_en = 1'b0;
      while (c < 64) begin step(); if (bus.sseg === 8'hA4) seen++; end
      n_cmp++; if (bus.commit_pend !== 1'b0) begin n_bad++; $display("FAIL nocommit_pend: got %b want 0", bus.commit_pend); end
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      n_cmp++; if (bus.commit_pend !== 1'b1) begin n_bad++; $display("FAIL commit_set: got %b want 1", bus.commit_pend); end
      while (c < 127) begin step(); if (bus.sseg === 8'hA4) seen++; end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL commit_early: got %0d cycles of a4 want 0", seen); end
      n_cmp++; if (bus.commit_pend !== 1'b1) begin n_bad++; $display("FAIL commit_hold: got %b want 1", bus.commit_pend); end
      step();
      n_cmp++; if (bus.commit_pend !== 1'b0 || bus.frame_tick !== 1'b1) begin n_bad++; $display("FAIL commit_clear: got pend=%b ftick=%b want 0/1", bus.commit_pend, bus.frame_tick); end
      run_to(133);
      n_cmp++; if (bus.sseg !== 8'hFF || bus.an !== 4'hE) begin n_bad++; $display("FAIL commit_slot0: got %h/%b want ff/1110", bus.sseg, bus.an); end
      run_to(164);
      n_cmp++; if (bus.sseg !== 8'hFF) begin n_bad++; $display("FAIL commit_guard2: got %h want ff", bus.sseg); end
      step();
      n_cmp++; if (bus.sseg !== 8'hA4 || bus.an !== 4'hB) begin n_bad++; $display("FAIL commit_show: got %h/%b want a4/1011", bus.sseg, bus.an); end
      run_to(176);
      n_cmp++; if (bus.sseg !== 8'hA4) begin n_bad++; $display("FAIL commit_last: got %h want a4", bus.sseg); end
      step();
      n_cmp++; if (bus.sseg !== 8'hFF) begin n_bad++; $display("FAIL commit_after: got %h want ff", bus.sseg); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      run_to(63);
      bus.commit = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'hC0;
      step();
      bus.commit = 1'b0; bus.wr_en = 1'b0;
      n_cmp++; if (bus.commit_pend !== 1'b1 || bus.frame_tick !== 1'b1) begin n_bad++; $display("FAIL b2b_pend: got pend=%b ftick=%b want 1/1", bus.commit_pend, bus.frame_tick); end
      run_to(69);
      n_cmp++; if (bus.sseg !== 8'hFF || bus.an !== 4'hE) begin n_bad++; $display("FAIL b2b_nocopy: got %h/%b want ff/1110", bus.sseg, bus.an); end
      run_to(128);
      n_cmp++; if (bus.commit_pend !== 1'b0) begin n_bad++; $display("FAIL b2b_clear: got %b want 0", bus.commit_pend); end
      run_to(133);
      n_cmp++; if (bus.sseg !== 8'hC0 || bus.an !== 4'hE) begin n_bad++; $display("FAIL b2b_show: got %h/%b want c0/1110", bus.sseg, bus.an); end
   endtask

   task automatic test_digit_en;
      int lows [N];
      int want [N] = '{12, 12, 0, 12};
      for (int i = 0; i < N; i++) lows[i] = 0;
      bus.digit_en = 4'b1011;
      do_reset();
      repeat (64) begin
         step();
         for (int i = 0; i < N; i++) if (bus.an[i] === 1'b0) lows[i]++;
      end
      for (int i = 0; i < N; i++) begin
         n_cmp++; if (lows[i] != want[i]) begin n_bad++; $display("FAIL den_low_d%0d: got %0d want %0d", i, lows[i], want[i]); end
      end
      run_to(70);
      n_cmp++; if (bus.an !== 4'hE) begin n_bad++; $display("FAIL den_on: got %b want 1110", bus.an); end
      bus.digit_en = 4'b1010;
      step();
      n_cmp++; if (bus.an !== 4'hF) begin n_bad++; $display("FAIL den_blank: got %b want 1111", bus.an); end
      bus.digit_en = 4'b1011;
      step();
      n_cmp++; if (bus.an !== 4'hE) begin n_bad++; $display("FAIL den_relight: got %b want 1110", bus.an); end
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      n_cmp++; if (bus.commit_pend !== 1'b1) begin n_bad++; $display("FAIL den_pend: got %b want 1", bus.commit_pend); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (bus.an !== 4'hF || bus.sseg !== 8'hFF || bus.commit_pend !== 1'b0) begin n_bad++; $display("FAIL midreset: got an=%b sseg=%h pend=%b want 1111/ff/0", bus.an, bus.sseg, bus.commit_pend); end
      bus.digit_en = 4'hF;
   endtask

   task automatic test_bad_addr;
      int cs [4] = '{69, 85, 101, 117};
      do_reset();
      bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 8'h00;
      step();
      bus.wr_addr = 3'd4;
      step();
      bus.wr_en = 1'b0; bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      run_to(64);
      n_cmp++; if (bus.commit_pend !== 1'b0) begin n_bad++; $display("FAIL badaddr_pend: got %b want 0", bus.commit_pend); end
      for (int k = 0; k < 4; k++) begin
         run_to(cs[k]);
         n_cmp++; if (bus.sseg !== 8'hFF) begin n_bad++; $display("FAIL badaddr_d%0d: got %h want ff", k, bus.sseg); end
      end
   endtask

   task automatic count_frame(input logic [3:0] d, output int lit);
      lit = 0;
      bus.duty = d;
      do_reset();
      repeat (64) begin step(); if (bus.an !== 4'hF) lit++; end
   endtask

   task automatic test_duty;
      int lit;
`ifdef SSEG_PWM_EN
      count_frame(4'd1, lit);
      n_cmp++; if (lit != 16) begin n_bad++; $display("FAIL pwm_duty1: got %0d lit cycles want 16", lit); end
      count_frame(4'd0, lit);
      n_cmp++; if (lit != 0) begin n_bad++; $display("FAIL pwm_duty0: got %0d lit cycles want 0", lit); end
      count_frame(4'd15, lit);
      n_cmp++; if (lit != 48) begin n_bad++; $display("FAIL pwm_duty15: got %0d lit cycles want 48", lit); end
`else
      count_frame(4'd0, lit);
      n_cmp++; if (lit != 48) begin n_bad++; $display("FAIL duty_ignored0: got %0d lit cycles want 48", lit); end
      count_frame(4'd1, lit);
      n_cmp++; if (lit != 48) begin n_bad++; $display("FAIL duty_ignored1: got %0d lit cycles want 48", lit); end
`endif
      bus.duty = 4'd15;
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.wr_addr = 3'd0;
      bus.wr_data = 8'h00;
      bus.commit = 1'b0;
      bus.digit_en = 4'hF;
      bus.duty = 4'd15;
      test_reset();
      test_scan();
      test_commit();
      test_back_to_back();
      test_digit_en();
      test_bad_addr();
      test_duty();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
